mxfp_block_serializer: RTL and testbench
========================================

Name: mxfp_block_serializer

Overview:
- Downstream stage of the bf16-to-MXFP converter.
- Accepts one complete MX block per handshake: k packed MXFP elements plus one shared 8-bit E8M0 scale.
- Streams the elements out over a narrower valid/ready bus, `lanes` elements per beat. The scale is held on a sideband for the whole block.
- Decouples the wide, fixed-rate converter output from narrow, back-pressured consumers such as memory writers and link packers.

Parameters:
- exp_width, 3, element exponent bits.
- man_width, 2, element mantissa bits.
- bit_width, 1+exp_width+man_width, packed element width (derived).
- k, 32, elements per MX block.
- lanes, 8, elements per output beat. k mod lanes must be 0; otherwise elaboration fails via $error.
- beats, k/lanes, beats per block (derived).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  input block valid
- o_ready  out  1  input block accepted when i_valid && o_ready
- i_mx_vec  in  [bit_width-1:0] x k  block elements, unpacked array indexed 0..k-1
- i_mx_exp  in  8  shared block scale (E8M0)
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_data  out  lanes*bit_width  beat payload
- o_mx_exp  out  8  scale of the block currently being sent
- o_first  out  1  beat 0 of block
- o_last  out  1  beat beats-1 of block

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state=IDLE, beat counter=0.
  - o_valid=0, o_first=0, o_last=0, o_data=0, o_mx_exp=0.
  - o_ready is forced 0 while i_rst_n is low.
- State machine:
  - IDLE: o_ready=1. On i_valid: capture i_mx_vec and i_mx_exp into the block register, set cnt=0, go to SEND.
  - SEND: o_valid=1. A beat transfers when o_valid && i_ready.
    - A transfer with cnt<beats-1 increments cnt.
    - A transfer with cnt==beats-1 ends the block. If i_valid that same cycle, capture the new block, set cnt=0 and stay in SEND. Otherwise go to IDLE.
  - o_ready = (state==IDLE) || (o_valid && i_ready && o_last). Combinational from state and i_ready.
- Latency: block accepted at edge N gives beat 0 valid in the cycle after edge N. With i_ready held high, block throughput is exactly `beats` cycles per block, with no bubbles between back-to-back blocks.
- Beat mapping: o_data[j*bit_width +: bit_width] = element cnt*lanes + j, for j=0..lanes-1. Lane 0 is in the LSBs.
- Flags: o_first = (cnt==0) && o_valid. o_last = (cnt==beats-1) && o_valid.
- o_mx_exp is constant from beat 0 through the last beat of a block.
- Backpressure: while o_valid && !i_ready, o_data, o_first, o_last and o_mx_exp hold stable.
- Input side:
  - i_valid while o_ready=0 has no effect; upstream holds its data.
  - The block register is written only on the accept handshake.
- Reset mid-block: the partial block is discarded. o_valid is low in the cycle after the reset edge. No resumption.
- beats==1 (lanes==k): every beat has o_first=o_last=1. o_ready follows i_ready while in SEND.
- The block's element content is not inspected; payload bits pass through unmodified.

Optional Feature:
- Macro MXFP_SER_NAN_FLAG_EN.
- Defined:
  - Adds output o_blk_nan (1 bit, reset 0).
  - At accept, the block register also stores (i_mx_exp==8'hFF). o_blk_nan is asserted on every beat of that block (gated by o_valid).
  - o_data for a NaN-scale block is driven all-zero.
- Undefined: no port; payload is always passed through.

Decomposition:
- Package mx_pkg:
  - E8M0 width constant (8).
  - E8M0 NaN constant 8'hFF.
  - Function mx_bit_width(exp_width, man_width).
  - Typedef for the serializer state enum {IDLE, SEND}.
- No sub-module is required. The beat-select mux is an indexed part-select of the flattened block register.

Test Plan (lanes=8, k=32, bit_width=6, beats=4):
- Single block: elem[i]=i, exp=8'h7A, i_ready=1 -> 4 beats on consecutive cycles starting the cycle after accept. Beat 1 lane 0 = 6'd8. o_first on beat 0 only, o_last on beat 3 only, o_mx_exp=8'h7A throughout.
- Back-to-back: two blocks offered with i_valid held high -> second accepted on the beat-3 cycle of the first. 8 contiguous valid beats. o_mx_exp switches exactly at second o_first.
- Backpressure: i_ready low for 3 cycles during beat 2 -> o_data, o_last and o_mx_exp are unchanged over those cycles. Beat 2 transfers once. o_ready stays 0.
- Input stall: i_valid pulsed during SEND beat 1 with new data -> ignored. Block register unchanged. Held i_valid accepted at the last beat.
- Reset mid-block: i_rst_n low during beat 1 -> next cycle o_valid=0, o_mx_exp=0. After release, o_ready=1 and a fresh block starts at beat 0.
- MXFP_SER_NAN_FLAG_EN: exp=8'hFF with nonzero elements -> o_blk_nan=1 on all 4 beats and o_data=0. Following block with exp=8'h7F -> o_blk_nan=0 and payload passed through.

Source files
------------

// File: rtl/mx_pkg.sv
// rtl/mx_pkg.sv - shared MXFP constants, element-width helper and serializer state type
package mx_pkg;

    localparam int E8M0_WIDTH = 8;
    localparam logic [E8M0_WIDTH-1:0] E8M0_NAN = 8'hFF;

    localparam logic [0:0] SER_IDLE = 1'b0;
    localparam logic [0:0] SER_SEND = 1'b1;

    typedef enum logic [0:0] {
        IDLE = SER_IDLE,
        SEND = SER_SEND
    } ser_state_t;

    function automatic int mx_bit_width(input int exp_width, input int man_width);
        return 1 + exp_width + man_width;
    endfunction

endpackage

// File: rtl/mxfp_block_serializer.sv
// rtl/mxfp_block_serializer.sv - MX block to narrow beat stream serializer with scale sideband
// Optional MXFP_SER_NAN_FLAG_EN adds o_blk_nan and zeroes the payload of NaN-scale blocks.
module mxfp_block_serializer
    import mx_pkg::*;
#(
    parameter int exp_width = 3,
    parameter int man_width = 2,
    parameter int k         = 32,
    parameter int lanes     = 8,
    localparam int bit_width = mx_bit_width(exp_width, man_width),
    localparam int beats     = k / lanes
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [bit_width-1:0]        i_mx_vec [k],
    input  logic [E8M0_WIDTH-1:0]       i_mx_exp,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [lanes*bit_width-1:0]  o_data,
    output logic [E8M0_WIDTH-1:0]       o_mx_exp,
`ifdef MXFP_SER_NAN_FLAG_EN
    output logic                        o_blk_nan,
`endif
    output logic                        o_first,
    output logic                        o_last
);

    localparam int beat_w = lanes * bit_width;
    localparam int cnt_w  = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);

    if (k % lanes != 0) begin : g_bad_cfg
        $error("mxfp_block_serializer: k must be a multiple of lanes");
    end

    ser_state_t                 state;
    logic [cnt_w-1:0]           cnt;
    logic [k*bit_width-1:0]     blk;
    logic [k*bit_width-1:0]     vec_flat;
    logic [E8M0_WIDTH-1:0]      blk_exp;
    logic [beat_w-1:0]          beat_sel [2**cnt_w];
    logic                       accept;
    logic                       xfer;
    logic                       beat_last;

    for (genvar i = 0; i < k; i++) begin : g_flat
        assign vec_flat[i*bit_width +: bit_width] = i_mx_vec[i];
    end

    // Select table padded to a power of two so cnt indexes it without width games.
    for (genvar b = 0; b < 2**cnt_w; b++) begin : g_beat
        if (b < beats) begin : g_live
            assign beat_sel[b] = blk[b*beat_w +: beat_w];
        end else begin : g_pad
            assign beat_sel[b] = '0;
        end
    end

    assign o_valid   = (state == SEND);
    assign beat_last = (cnt == last_cnt);
    assign xfer      = o_valid && i_ready;
    assign o_ready   = i_rst_n && ((state == IDLE) || (xfer && beat_last));
    assign accept    = i_valid && o_ready;
    assign o_first   = o_valid && (cnt == '0);
    assign o_last    = o_valid && beat_last;
    assign o_mx_exp  = blk_exp;

`ifdef MXFP_SER_NAN_FLAG_EN
    logic blk_nan;

    assign o_data    = blk_nan ? '0 : beat_sel[cnt];
    assign o_blk_nan = blk_nan && o_valid;
`else
    assign o_data    = beat_sel[cnt];
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            blk     <= '0;
            blk_exp <= '0;
`ifdef MXFP_SER_NAN_FLAG_EN
            blk_nan <= 1'b0;
`endif
        end else if (accept) begin
            // Also covers the back-to-back case: accept in SEND only happens on the last beat.
            state   <= SEND;
            cnt     <= '0;
            blk     <= vec_flat;
            blk_exp <= i_mx_exp;
`ifdef MXFP_SER_NAN_FLAG_EN
            blk_nan <= (i_mx_exp == E8M0_NAN);
`endif
        end else if (xfer) begin
            if (beat_last) begin
                state <= IDLE;
            end else begin
                cnt <= cnt + cnt_w'(1);
            end
        end
    end

endmodule

// File: tb/tb_mxfp_block_serializer.sv
// tb/tb_mxfp_block_serializer.sv - scoreboard bench for mxfp_block_serializer (k=32, lanes=8)
module tb_mxfp_block_serializer;

    localparam int BW    = 6;
    localparam int K     = 32;
    localparam int L     = 8;
    localparam int BEATS = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [BW-1:0]     vec [K];
    logic [7:0]        mx_exp = 8'h00;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [L*BW-1:0]   o_data;
    logic [7:0]        o_mx_exp;
    logic              o_first;
    logic              o_last;
`ifdef MXFP_SER_NAN_FLAG_EN
    logic              o_blk_nan;
`endif

    always #5 clk = ~clk;

    mxfp_block_serializer #(
        .exp_width (3),
        .man_width (2),
        .k         (K),
        .lanes     (L)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_mx_vec  (vec),
        .i_mx_exp  (mx_exp),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_mx_exp  (o_mx_exp),
`ifdef MXFP_SER_NAN_FLAG_EN
        .o_blk_nan (o_blk_nan),
`endif
        .o_first   (o_first),
        .o_last    (o_last)
    );

    typedef struct {
        logic [L*BW-1:0] data;
        logic [7:0]      e;
        logic            first;
        logic            last;
        logic            nan;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic beat_t model_beat(input int b);
        beat_t r;
        r.data = '0;
        for (int j = 0; j < L; j++) r.data[j*BW +: BW] = vec[b*L + j];
        r.e     = mx_exp;
        r.first = (b == 0);
        r.last  = (b == BEATS - 1);
        r.nan   = (mx_exp == 8'hFF);
`ifdef MXFP_SER_NAN_FLAG_EN
        if (r.nan) r.data = '0;
`endif
        return r;
    endfunction

    // Transfers resolve at the next posedge from values that are stable at negedge.
    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst_n) begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    b = sb.pop_front();
                    check("sb_data", 64'(o_data), 64'(b.data));
                    check("sb_exp", 64'(o_mx_exp), 64'(b.e));
                    check("sb_first", 64'(o_first), 64'(b.first));
                    check("sb_last", 64'(o_last), 64'(b.last));
`ifdef MXFP_SER_NAN_FLAG_EN
                    check("sb_nan", 64'(o_blk_nan), 64'(b.nan));
`endif
                end
            end
            if (i_valid && o_ready) begin
                for (int i = 0; i < BEATS; i++) sb.push_back(model_beat(i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input int seed, input logic [7:0] e);
        for (int i = 0; i < K; i++) vec[i] = BW'(i + seed);
        mx_exp = e;
    endtask

    task automatic load_rand(input logic [7:0] e);
        for (int i = 0; i < K; i++) vec[i] = BW'($urandom_range(1, 63));
        mx_exp = e;
    endtask

    logic [L*BW-1:0] snap_data;

    initial begin
        load_seq(0, 8'h00);

        // reset state
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_first", 64'(o_first), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_exp", 64'(o_mx_exp), 64'd0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", 64'(o_ready), 64'd1);
        tick();

        // single block, elem[i]=i
        i_ready = 1'b1;
        load_seq(0, 8'h7A);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < BEATS; c++) begin
            check("single_valid", 64'(o_valid), 64'd1);
            check("single_first", 64'(o_first), 64'(c == 0));
            check("single_last", 64'(o_last), 64'(c == BEATS - 1));
            check("single_exp", 64'(o_mx_exp), 64'h7A);
            if (c == 1) check("beat1_lane0", 64'(o_data[BW-1:0]), 64'd8);
            tick();
        end
        check("single_done_valid", 64'(o_valid), 64'd0);
        check("single_done_ready", 64'(o_ready), 64'd1);

        // back-to-back with i_valid held high
        load_seq(5, 8'h11);
        i_valid = 1'b1;
        tick();
        load_rand(8'h22);
        for (int c = 0; c < 2*BEATS; c++) begin
            check("b2b_valid", 64'(o_valid), 64'd1);
            check("b2b_first", 64'(o_first), 64'(c % BEATS == 0));
            check("b2b_exp", 64'(o_mx_exp), (c < BEATS) ? 64'h11 : 64'h22);
            if (c == 1) check("b2b_mid_ready", 64'(o_ready), 64'd0);
            if (c == BEATS - 1) check("b2b_last_ready", 64'(o_ready), 64'd1);
            tick();
            if (c == BEATS - 1) i_valid = 1'b0;
        end
        check("b2b_done_valid", 64'(o_valid), 64'd0);

        // backpressure on beat 2
        load_rand(8'h5C);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_ready = 1'b0;
        snap_data = o_data;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_valid", 64'(o_valid), 64'd1);
            check("bp_data", 64'(o_data), 64'(snap_data));
            check("bp_last", 64'(o_last), 64'd0);
            check("bp_first", 64'(o_first), 64'd0);
            check("bp_exp", 64'(o_mx_exp), 64'h5C);
            check("bp_ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        tick();
        check("bp_beat3_last", 64'(o_last), 64'd1);
        tick();
        check("bp_done_valid", 64'(o_valid), 64'd0);

        // input stall: pulse during beat 1 is ignored, held valid accepted at last beat
        load_seq(3, 8'h33);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        load_rand(8'h44);
        i_valid = 1'b1;
        check("stall_ready", 64'(o_ready), 64'd0);
        tick();
        load_seq(9, 8'h55);
        check("stall_exp_kept", 64'(o_mx_exp), 64'h33);
        tick();
        check("stall_last_ready", 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        check("stall_new_first", 64'(o_first), 64'd1);
        check("stall_new_exp", 64'(o_mx_exp), 64'h55);
        for (int c = 0; c < BEATS; c++) tick();
        check("stall_done_valid", 64'(o_valid), 64'd0);

        // reset mid-block
        load_rand(8'h66);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        sb.delete();
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_exp", 64'(o_mx_exp), 64'd0);
        check("midrst_ready", 64'(o_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_ready", 64'(o_ready), 64'd1);
        load_seq(17, 8'h77);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("midrst_fresh_first", 64'(o_first), 64'd1);
        check("midrst_fresh_exp", 64'(o_mx_exp), 64'h77);
        for (int c = 0; c < BEATS; c++) tick();

`ifdef MXFP_SER_NAN_FLAG_EN
        // NaN-scale block followed by a normal block
        load_rand(8'hFF);
        i_valid = 1'b1;
        tick();
        load_rand(8'h7F);
        for (int c = 0; c < 2*BEATS; c++) begin
            check("nan_flag", 64'(o_blk_nan), (c < BEATS) ? 64'd1 : 64'd0);
            if (c < BEATS) check("nan_data_zero", 64'(o_data), 64'd0);
            tick();
            if (c == BEATS - 1) i_valid = 1'b0;
        end
        check("nan_done_flag", 64'(o_blk_nan), 64'd0);
`endif

        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
